// File: rtl/mmwb_stage_reg_pkg.sv
// Shared types for the MEM/WB stage: datapath word, register index and writeback select.
package mmwb_stage_reg_pkg;

  localparam int unsigned WordW = 32;
  localparam int unsigned RegAw = 5;

  typedef logic [WordW-1:0] word_t;
  typedef logic [RegAw-1:0] regbits_t;

  typedef enum logic [1:0] {
    MTR_ALU  = 2'd0,
    MTR_LOAD = 2'd1,
    MTR_NPC  = 2'd2,
    MTR_EQ   = 2'd3
  } memtoreg_t;

endpackage

// File: rtl/mmwb_stage_reg_wdat_mux.sv
// Writeback data select: 4:1 mux on memtoreg_t, shared with the forwarding unit.
module mmwb_stage_reg_wdat_mux
  import mmwb_stage_reg_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  memtoreg_t         sel_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] load_i,
  input  logic [DATA_W-1:0] npc_i,
  input  logic              equal_i,
  output logic [DATA_W-1:0] wdat_o
);

  always_comb begin
    wdat_o = '0;
    unique case (sel_i)
      MTR_ALU:  wdat_o = alu_i;
      MTR_LOAD: wdat_o = load_i;
      MTR_NPC:  wdat_o = npc_i;
      MTR_EQ:   wdat_o = {{(DATA_W-1){1'b0}}, equal_i};
      default:  wdat_o = '0;
    endcase
  end

endmodule

// File: rtl/mmwb_stage_reg.sv
// MEM/WB pipeline register with stall/flush, writeback select, sticky halt and retire counter.
module mmwb_stage_reg
  import mmwb_stage_reg_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              en,
  input  logic              flush,
  input  logic              mm_valid,
  input  memtoreg_t         mm_MemtoReg,
  input  logic              mm_RegWEN,
  input  logic              mm_equal,
  input  logic              mm_halt,
  input  logic [REG_AW-1:0] mm_rd,
  input  logic [DATA_W-1:0] mm_portB,
  input  logic [DATA_W-1:0] mm_npc,
  input  logic [DATA_W-1:0] mm_ALUOut,
  input  logic [DATA_W-1:0] mm_load,
  output logic              wb_valid,
  output logic              wb_WEN,
  output logic [REG_AW-1:0] wb_wsel,
  output logic [DATA_W-1:0] wb_wdat,
  output logic              wb_halt,
  output logic [DATA_W-1:0] wb_portB,
  output logic [CNT_W-1:0]  retired
);

  logic              valid_q, valid_d;
  logic              regwen_q, regwen_d;
  logic              equal_q, equal_d;
  logic              halt_q, halt_d;
  memtoreg_t         mtr_q, mtr_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] portb_q, portb_d;
  logic [DATA_W-1:0] npc_q, npc_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] load_q, load_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic capture, bubble, retire;

  // After HALT nothing new is admitted; an advance or flush only shifts in bubbles.
  assign capture = en & ~flush & ~halt_q;
  assign bubble  = flush | (en & halt_q);
  assign retire  = valid_q & (en | flush);

  always_comb begin
    valid_d  = valid_q;
    regwen_d = regwen_q;
    equal_d  = equal_q;
    mtr_d    = mtr_q;
    rd_d     = rd_q;
    portb_d  = portb_q;
    npc_d    = npc_q;
    alu_d    = alu_q;
    load_d   = load_q;
    if (capture) begin
      valid_d  = mm_valid;
      regwen_d = mm_RegWEN;
      equal_d  = mm_equal;
      mtr_d    = mm_MemtoReg;
      rd_d     = mm_rd;
      portb_d  = mm_portB;
      npc_d    = mm_npc;
      alu_d    = mm_ALUOut;
      load_d   = mm_load;
    end else if (bubble) begin
      valid_d  = 1'b0;
      regwen_d = 1'b0;
    end
    halt_d    = halt_q | (capture & mm_valid & mm_halt);
    retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q   <= 1'b0;
      regwen_q  <= 1'b0;
      equal_q   <= 1'b0;
      halt_q    <= 1'b0;
      mtr_q     <= MTR_ALU;
      rd_q      <= '0;
      portb_q   <= '0;
      npc_q     <= '0;
      alu_q     <= '0;
      load_q    <= '0;
      retired_q <= '0;
    end else begin
      valid_q   <= valid_d;
      regwen_q  <= regwen_d;
      equal_q   <= equal_d;
      halt_q    <= halt_d;
      mtr_q     <= mtr_d;
      rd_q      <= rd_d;
      portb_q   <= portb_d;
      npc_q     <= npc_d;
      alu_q     <= alu_d;
      load_q    <= load_d;
      retired_q <= retired_d;
    end
  end

  mmwb_stage_reg_wdat_mux #(
    .DATA_W (DATA_W)
  ) u_wdat_mux (
    .sel_i   (mtr_q),
    .alu_i   (alu_q),
    .load_i  (load_q),
    .npc_i   (npc_q),
    .equal_i (equal_q),
    .wdat_o  (wb_wdat)
  );

  // Writes to $0 are dropped here so the register file needs no guard of its own.
  assign wb_valid = valid_q;
  assign wb_WEN   = valid_q & regwen_q & (rd_q != '0);
  assign wb_wsel  = rd_q;
  assign wb_halt  = halt_q;
  assign wb_portB = portb_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_mmwb_stage_reg.sv
// Directed bench for mmwb_stage_reg: select, $0 guard, stall/flush, halt, reset and counter wrap.
module tb_mmwb_stage_reg;
  import mmwb_stage_reg_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        en, flush, mm_valid, mm_RegWEN, mm_equal, mm_halt;
  memtoreg_t   mm_MemtoReg;
  logic [4:0]  mm_rd;
  logic [31:0] mm_portB, mm_npc, mm_ALUOut, mm_load;

  logic        wb_valid, wb_WEN, wb_halt;
  logic [4:0]  wb_wsel;
  logic [31:0] wb_wdat, wb_portB, retired;

  logic        wb_valid4, wb_WEN4, wb_halt4;
  logic [4:0]  wb_wsel4;
  logic [31:0] wb_wdat4, wb_portB4;
  logic [3:0]  retired4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  mmwb_stage_reg u_dut (
    .CLK(CLK), .RST(RST), .en(en), .flush(flush), .mm_valid(mm_valid),
    .mm_MemtoReg(mm_MemtoReg), .mm_RegWEN(mm_RegWEN), .mm_equal(mm_equal),
    .mm_halt(mm_halt), .mm_rd(mm_rd), .mm_portB(mm_portB), .mm_npc(mm_npc),
    .mm_ALUOut(mm_ALUOut), .mm_load(mm_load), .wb_valid(wb_valid), .wb_WEN(wb_WEN),
    .wb_wsel(wb_wsel), .wb_wdat(wb_wdat), .wb_halt(wb_halt), .wb_portB(wb_portB),
    .retired(retired)
  );

  mmwb_stage_reg #(.CNT_W(4)) u_dut4 (
    .CLK(CLK), .RST(RST), .en(en), .flush(flush), .mm_valid(mm_valid),
    .mm_MemtoReg(mm_MemtoReg), .mm_RegWEN(mm_RegWEN), .mm_equal(mm_equal),
    .mm_halt(mm_halt), .mm_rd(mm_rd), .mm_portB(mm_portB), .mm_npc(mm_npc),
    .mm_ALUOut(mm_ALUOut), .mm_load(mm_load), .wb_valid(wb_valid4), .wb_WEN(wb_WEN4),
    .wb_wsel(wb_wsel4), .wb_wdat(wb_wdat4), .wb_halt(wb_halt4), .wb_portB(wb_portB4),
    .retired(retired4)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  logic [31:0] sel_exp [4];

  initial begin
    RST = 1'b1; en = 1'b0; flush = 1'b0; mm_valid = 1'b0; mm_RegWEN = 1'b0;
    mm_equal = 1'b0; mm_halt = 1'b0; mm_MemtoReg = MTR_ALU; mm_rd = '0;
    mm_portB = '0; mm_npc = '0; mm_ALUOut = '0; mm_load = '0;
    step(); step();
    check_eq("rst_valid", wb_valid, 0);
    check_eq("rst_wen", wb_WEN, 0);
    check_eq("rst_halt", wb_halt, 0);
    check_eq("rst_retired", retired, 0);
    check_eq("rst_wdat", wb_wdat, 0);
    RST = 1'b0;

    // Writeback select, one cycle after capture
    sel_exp[0] = 32'h11; sel_exp[1] = 32'h22; sel_exp[2] = 32'h33; sel_exp[3] = 32'h1;
    en = 1'b1; mm_valid = 1'b1; mm_RegWEN = 1'b1; mm_rd = 5'd3;
    mm_ALUOut = 32'h11; mm_load = 32'h22; mm_npc = 32'h33; mm_equal = 1'b1;
    mm_portB = 32'hABCD;
    for (int m = 0; m < 4; m++) begin
      mm_MemtoReg = memtoreg_t'(m);
      step();
      check_eq($sformatf("sel_%0d", m), wb_wdat, sel_exp[m]);
    end
    check_eq("sel_portb", wb_portB, 32'hABCD);
    check_eq("sel_retired", retired, 3);

    // $0 write guard
    mm_MemtoReg = MTR_ALU; mm_rd = 5'd0; mm_ALUOut = 32'hDEAD;
    step();
    check_eq("r0_wen", wb_WEN, 0);
    check_eq("r0_wdat", wb_wdat, 32'hDEAD);
    mm_rd = 5'd5;
    step();
    check_eq("r5_wen", wb_WEN, 1);
    check_eq("r5_wsel", wb_wsel, 5);
    check_eq("r5_retired", retired, 5);

    // Stall then flush
    mm_rd = 5'd7; mm_ALUOut = 32'h77;
    step();
    check_eq("st_retired0", retired, 6);
    en = 1'b0; mm_rd = 5'd9; mm_ALUOut = 32'h55;
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq($sformatf("st_wsel_%0d", c), wb_wsel, 7);
      check_eq($sformatf("st_wdat_%0d", c), wb_wdat, 32'h77);
      check_eq($sformatf("st_wen_%0d", c), wb_WEN, 1);
    end
    check_eq("st_retired", retired, 6);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("fl_valid", wb_valid, 0);
    check_eq("fl_wen", wb_WEN, 0);
    check_eq("fl_retired", retired, 7);

    // HALT followed by two valid ALU ops
    en = 1'b1; mm_halt = 1'b1; mm_RegWEN = 1'b0; mm_rd = 5'd0;
    step();
    check_eq("h_halt", wb_halt, 1);
    check_eq("h_valid", wb_valid, 1);
    check_eq("h_retired0", retired, 7);
    mm_halt = 1'b0; mm_RegWEN = 1'b1; mm_rd = 5'd4; mm_ALUOut = 32'h44;
    for (int c = 0; c < 2; c++) begin
      step();
      check_eq($sformatf("h_sticky_%0d", c), wb_halt, 1);
      check_eq($sformatf("h_wen_%0d", c), wb_WEN, 0);
      check_eq($sformatf("h_retired_%0d", c), retired, 8);
    end

    // Mid-cycle reset with a valid LOAD in flight
    RST = 1'b1; step(); RST = 1'b0;
    mm_MemtoReg = MTR_LOAD; mm_rd = 5'd2; mm_load = 32'h22;
    step();
    check_eq("ld_wen", wb_WEN, 1);
    check_eq("ld_wdat", wb_wdat, 32'h22);
    #3 RST = 1'b1;
    #1;
    check_eq("mr_valid", wb_valid, 0);
    check_eq("mr_wen", wb_WEN, 0);
    check_eq("mr_wdat", wb_wdat, 0);
    check_eq("mr_retired", retired, 0);
    step();
    RST = 1'b0;

    // 17 retirements: 4-bit counter wraps to 1
    mm_MemtoReg = MTR_ALU; mm_RegWEN = 1'b0;
    for (int c = 0; c < 18; c++) step();
    check_eq("wrap_cnt4", retired4, 1);
    check_eq("wrap_cnt32", retired, 17);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
